hilo_ctrl: RTL and testbench

Sequencer and architectural HI/LO register pair sitting directly downstream of the multiply/divide unit. It detects MULT/MULTU/DIV/DIVU in EX, drives the MDU's control, enable and clear inputs, and stalls the pipeline until the MDU reports ready. It then commits the 64-bit result into HI/LO, arbitrates against MTHI/MTLO writes from WB, and serves MFHI/MFLO reads.

---
 rtl/hilo_ctrl_pkg.sv | 34 +++
 rtl/hilo_ctrl_if.sv | 33 +++
 rtl/hilo_regs.sv | 56 +++++
 rtl/hilo_ctrl.sv | 91 +++++++++
 tb/tb_hilo_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hilo_ctrl_pkg.sv
// Shared MDU control codes, FSM state encoding and helpers for the HI/LO sequencer.
package hilo_ctrl_pkg;

  localparam logic [4:0] MULT_CONTROL  = 5'b11000;
  localparam logic [4:0] MULTU_CONTROL = 5'b11001;
  localparam logic [4:0] DIV_CONTROL   = 5'b11010;
  localparam logic [4:0] DIVU_CONTROL  = 5'b11011;

  localparam int unsigned CtrlW = 5;
  localparam int unsigned CntW  = 6;
  localparam logic [CntW-1:0] CntMax = '1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  function automatic logic is_mdu_code(input logic [CtrlW-1:0] ctrl);
    logic hit;
    hit = 1'b0;
    unique case (ctrl)
      MULT_CONTROL, MULTU_CONTROL, DIV_CONTROL, DIVU_CONTROL: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/hilo_ctrl_if.sv
// Pipeline/MDU/WB signal bundle of the HI/LO sequencer; slave is the sequencer side.
interface hilo_ctrl_if;
  import hilo_ctrl_pkg::*;

  logic             ex_valid;
  logic [CtrlW-1:0] ex_control;
  logic             flush;
  logic             mdu_ready;
  logic [63:0]      mdu_result;
  logic [CtrlW-1:0] mdu_control;
  logic             mdu_en;
  logic             mdu_clear;
  logic             stall;
  logic             wb_hi_we;
  logic             wb_lo_we;
  logic [31:0]      wb_wdata;
  logic [31:0]      rd_hi;
  logic [31:0]      rd_lo;
  logic [CntW-1:0]  busy_cycles;

  modport slave (
    input  ex_valid, ex_control, flush, mdu_ready, mdu_result,
    input  wb_hi_we, wb_lo_we, wb_wdata,
    output mdu_control, mdu_en, mdu_clear, stall, rd_hi, rd_lo, busy_cycles
  );

  modport master (
    output ex_valid, ex_control, flush, mdu_ready, mdu_result,
    output wb_hi_we, wb_lo_we, wb_wdata,
    input  mdu_control, mdu_en, mdu_clear, stall, rd_hi, rd_lo, busy_cycles
  );

endinterface

// File: rtl/hilo_regs.sv
// Architectural HI/LO pair: MDU commit beats MTHI/MTLO, which beat hold.
// Define HILO_FWD_EN to bypass a same-cycle MTHI/MTLO write onto the read ports.
module hilo_regs
  import hilo_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        commit,
  input  hilo_t       commit_data,
  input  logic        wb_hi_we,
  input  logic        wb_lo_we,
  input  logic [31:0] wb_wdata,
  output logic [31:0] rd_hi,
  output logic [31:0] rd_lo
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // The MDU op is younger than the WB instruction, so its commit overrides both halves.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit) begin
      hi_d = commit_data.hi;
      lo_d = commit_data.lo;
    end else begin
      if (wb_hi_we) hi_d = wb_wdata;
      if (wb_lo_we) lo_d = wb_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

`ifdef HILO_FWD_EN
  always_comb begin
    rd_hi = (wb_hi_we && !commit) ? wb_wdata : hi_q;
    rd_lo = (wb_lo_we && !commit) ? wb_wdata : lo_q;
  end
`else
  // Without the bypass the hazard unit interlocks MF* behind MT* in WB.
  always_comb begin
    rd_hi = hi_q;
    rd_lo = lo_q;
  end
`endif

endmodule

// File: rtl/hilo_ctrl.sv
// MDU sequencer: starts MULT/DIV ops from EX, stalls until ready, commits into HI/LO.
module hilo_ctrl
  import hilo_ctrl_pkg::*;
(
  input logic        clk,
  input logic        rst,
  hilo_ctrl_if.slave bus
);

  state_e           state_q;
  logic [CtrlW-1:0] op_q;
  logic [CntW-1:0]  busy_q;

  logic is_op;
  logic start;
  logic commit;

  assign is_op  = bus.ex_valid && is_mdu_code(bus.ex_control);
  assign start  = (state_q == StIdle) && is_op && !bus.flush;
  assign commit = (state_q == StBusy) && !bus.flush && bus.mdu_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      op_q    <= '0;
      busy_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StBusy;
            op_q    <= bus.ex_control;
            busy_q  <= '0;
          end
        end
        StBusy: begin
          // Only cycles that actually hold the pipeline are counted.
          if (bus.flush) begin
            state_q <= StIdle;
          end else if (bus.mdu_ready) begin
            state_q <= StDone;
          end else if (busy_q != CntMax) begin
            busy_q <= busy_q + CntW'(1);
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    bus.mdu_control = '0;
    bus.mdu_en      = 1'b0;
    bus.stall       = 1'b0;
    unique case (state_q)
      StIdle: begin
        bus.mdu_control = is_op ? bus.ex_control : '0;
        bus.mdu_en      = is_op;
        bus.stall       = is_op && !bus.flush;
      end
      StBusy: begin
        bus.mdu_control = op_q;
        bus.mdu_en      = 1'b1;
        bus.stall       = !bus.mdu_ready && !bus.flush;
      end
      // Control drops to zero for one cycle so the MDU releases its claim.
      StDone: bus.stall = is_op;
      default: ;
    endcase
  end

  assign bus.mdu_clear   = bus.flush;
  assign bus.busy_cycles = busy_q;

  hilo_regs u_hilo_regs (
    .clk         (clk),
    .rst         (rst),
    .commit      (commit),
    .commit_data (bus.mdu_result),
    .wb_hi_we    (bus.wb_hi_we),
    .wb_lo_we    (bus.wb_lo_we),
    .wb_wdata    (bus.wb_wdata),
    .rd_hi       (bus.rd_hi),
    .rd_lo       (bus.rd_lo)
  );

  assert property (@(posedge clk) disable iff (!rst) commit |=> state_q == StDone);
  assert property (@(posedge clk) disable iff (!rst) state_q == StDone |=> state_q == StIdle);

endmodule

// File: tb/tb_hilo_ctrl.sv
// Bench for hilo_ctrl: acts as pipeline, MDU and WB, checks against an arithmetic model.
module tb_hilo_ctrl;
  import hilo_ctrl_pkg::*;

`ifdef HILO_FWD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hilo_ctrl_if bus ();

  hilo_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] hi_m, lo_m;

  // MDU result as the ISA defines it: {HI, LO} = product, or {remainder, quotient}.
  function automatic logic [63:0] mdu_model(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    int qs, rs;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      MULT_CONTROL:  return 64'(sa * sb);
      MULTU_CONTROL: return 64'(ua * ub);
      DIV_CONTROL: begin
        qs = $signed(a) / $signed(b);
        rs = $signed(a) % $signed(b);
        return {rs, qs};
      end
      DIVU_CONTROL:  return {a % b, a / b};
      default:       return 64'h0;
    endcase
  endfunction

  function automatic logic [31:0] exp_rd(input logic [31:0] reg_v, input logic we,
                                         input logic commit, input logic [31:0] wd);
    return (Fwd && we && !commit) ? wd : reg_v;
  endfunction

  task automatic model_edge(input logic commit, input logic [63:0] res, input logic hwe,
                            input logic lwe, input logic [31:0] wd);
    if (commit) begin
      hi_m = res[63:32];
      lo_m = res[31:0];
    end else begin
      if (hwe) hi_m = wd;
      if (lwe) lo_m = wd;
    end
  endtask

  task automatic set_idle;
    bus.ex_valid   = 1'b0;
    bus.ex_control = '0;
    bus.flush      = 1'b0;
    bus.mdu_ready  = 1'b0;
    bus.mdu_result = '0;
    bus.wb_hi_we   = 1'b0;
    bus.wb_lo_we   = 1'b0;
    bus.wb_wdata   = '0;
  endtask

  task automatic set_op(input logic [4:0] op, input logic rdy, input logic [63:0] res);
    bus.ex_valid   = 1'b1;
    bus.ex_control = op;
    bus.mdu_ready  = rdy;
    bus.mdu_result = res;
  endtask

  task automatic test_reset;
    set_idle();
    rst = 1'b0;
    hi_m = '0;
    lo_m = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", bus.stall); end
    checks++; if (bus.mdu_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b exp 0", bus.mdu_en); end
    checks++; if (bus.mdu_control !== 5'd0) begin errors++; $display("FAIL reset_ctrl got %h exp 0", bus.mdu_control); end
    checks++; if (bus.rd_hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h exp 0", bus.rd_hi); end
    checks++; if (bus.rd_lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h exp 0", bus.rd_lo); end
    checks++; if (bus.busy_cycles !== 6'd0) begin errors++; $display("FAIL reset_busy got %0d exp 0", bus.busy_cycles); end
    checks++; if (bus.mdu_clear !== 1'b0) begin errors++; $display("FAIL reset_clear got %b exp 0", bus.mdu_clear); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_flush;
    logic [63:0] res;
    res = mdu_model(DIVU_CONTROL, 32'd100, 32'd7);
    set_op(DIVU_CONTROL, 1'b0, 64'h0);
    @(negedge clk);
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL flush_start_stall got %b exp 1", bus.stall); end
    checks++; if (bus.mdu_control !== DIVU_CONTROL) begin errors++; $display("FAIL flush_start_ctrl got %h exp %h", bus.mdu_control, DIVU_CONTROL); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL flush_busy1_stall got %b exp 1", bus.stall); end
    @(posedge clk); #1;
    // Flush and ready together: flush must win.
    bus.flush = 1'b1;
    set_op(DIVU_CONTROL, 1'b1, res);
    @(negedge clk);
    checks++; if (bus.mdu_clear !== 1'b1) begin errors++; $display("FAIL flush_clear got %b exp 1", bus.mdu_clear); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %b exp 0", bus.stall); end
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    checks++; if (bus.rd_hi !== 32'd0) begin errors++; $display("FAIL flush_hi got %h exp 0", bus.rd_hi); end
    checks++; if (bus.rd_lo !== 32'd0) begin errors++; $display("FAIL flush_lo got %h exp 0", bus.rd_lo); end
    checks++; if (bus.mdu_en !== 1'b0) begin errors++; $display("FAIL flush_idle_en got %b exp 0", bus.mdu_en); end
    @(posedge clk); #1;
    // Flush in IDLE with an op present: no start.
    bus.flush = 1'b1;
    set_op(DIVU_CONTROL, 1'b0, 64'h0);
    @(negedge clk);
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL idle_flush_stall got %b exp 0", bus.stall); end
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    checks++; if (bus.mdu_en !== 1'b0) begin errors++; $display("FAIL idle_flush_nostart got %b exp 0", bus.mdu_en); end
    @(posedge clk); #1;
  endtask

  task automatic test_mult;
    logic [63:0] res;
    int stall_cnt;
    res = mdu_model(MULT_CONTROL, 32'd3, 32'hFFFF_FFFE);
    stall_cnt = 0;
    for (int k = 0; k <= 5; k++) begin
      set_op(MULT_CONTROL, k == 5, (k == 5) ? res : 64'h0);
      @(negedge clk);
      if (bus.stall === 1'b1) stall_cnt++;
      @(posedge clk);
      model_edge(k == 5, res, 1'b0, 1'b0, 32'h0);
      #1;
    end
    set_idle();
    @(negedge clk);
    checks++; if (stall_cnt != 5) begin errors++; $display("FAIL mult_stall_cycles got %0d exp 5", stall_cnt); end
    checks++; if (bus.rd_hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h exp ffffffff", bus.rd_hi); end
    checks++; if (bus.rd_lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got %h exp fffffffa", bus.rd_lo); end
    checks++; if (bus.busy_cycles !== 6'd4) begin errors++; $display("FAIL mult_busy got %0d exp 4", bus.busy_cycles); end
    @(posedge clk); #1;
  endtask

  task automatic test_wb_collision;
    set_op(MULTU_CONTROL, 1'b0, 64'h0);
    @(posedge clk); #1;
    set_op(MULTU_CONTROL, 1'b1, {32'hA, 32'hB});
    bus.wb_hi_we = 1'b1;
    bus.wb_wdata = 32'h1234_5678;
    @(negedge clk);
    checks++; if (bus.rd_hi !== hi_m) begin errors++; $display("FAIL coll_rd_hi got %h exp %h", bus.rd_hi, hi_m); end
    @(posedge clk);
    model_edge(1'b1, {32'hA, 32'hB}, 1'b1, 1'b0, 32'h1234_5678);
    #1;
    set_idle();
    @(negedge clk);
    checks++; if (bus.rd_hi !== 32'hA) begin errors++; $display("FAIL coll_hi got %h exp a", bus.rd_hi); end
    checks++; if (bus.rd_lo !== 32'hB) begin errors++; $display("FAIL coll_lo got %h exp b", bus.rd_lo); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [63:0] r1, r2;
    r1 = mdu_model(MULTU_CONTROL, 32'hFFFF_FFFF, 32'd2);
    r2 = mdu_model(DIV_CONTROL, 32'hFFFF_FF9C, 32'd7);
    for (int k = 0; k <= 2; k++) begin
      set_op(MULTU_CONTROL, k == 2, (k == 2) ? r1 : 64'h0);
      @(negedge clk);
      checks++; if (bus.stall !== (k < 2)) begin errors++; $display("FAIL b2b_mul_stall k=%0d got %b exp %b", k, bus.stall, k < 2); end
      @(posedge clk);
      model_edge(k == 2, r1, 1'b0, 1'b0, 32'h0);
      #1;
    end
    set_op(DIV_CONTROL, 1'b0, 64'h0);
    @(negedge clk);
    checks++; if (bus.mdu_control !== 5'd0) begin errors++; $display("FAIL b2b_done_ctrl got %h exp 0", bus.mdu_control); end
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL b2b_done_stall got %b exp 1", bus.stall); end
    checks++; if (bus.mdu_en !== 1'b0) begin errors++; $display("FAIL b2b_done_en got %b exp 0", bus.mdu_en); end
    checks++; if ({bus.rd_hi, bus.rd_lo} !== r1) begin errors++; $display("FAIL b2b_first_res got %h exp %h", {bus.rd_hi, bus.rd_lo}, r1); end
    @(posedge clk); #1;
    for (int k = 0; k <= 3; k++) begin
      set_op(DIV_CONTROL, k == 3, (k == 3) ? r2 : 64'h0);
      @(negedge clk);
      checks++; if (bus.stall !== (k < 3)) begin errors++; $display("FAIL b2b_div_stall k=%0d got %b exp %b", k, bus.stall, k < 3); end
      checks++; if (bus.mdu_control !== DIV_CONTROL) begin errors++; $display("FAIL b2b_div_ctrl k=%0d got %h exp %h", k, bus.mdu_control, DIV_CONTROL); end
      @(posedge clk);
      model_edge(k == 3, r2, 1'b0, 1'b0, 32'h0);
      #1;
    end
    set_idle();
    @(negedge clk);
    checks++; if ({bus.rd_hi, bus.rd_lo} !== r2) begin errors++; $display("FAIL b2b_second_res got %h exp %h", {bus.rd_hi, bus.rd_lo}, r2); end
    @(posedge clk); #1;
  endtask

  task automatic test_wb_fwd;
    logic [31:0] wd;
    bus.wb_lo_we = 1'b1;
    bus.wb_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (bus.rd_lo !== exp_rd(lo_m, 1'b1, 1'b0, 32'hDEAD_BEEF)) begin errors++; $display("FAIL fwd_lo_same got %h exp %h", bus.rd_lo, exp_rd(lo_m, 1'b1, 1'b0, 32'hDEAD_BEEF)); end
    checks++; if (bus.rd_hi !== hi_m) begin errors++; $display("FAIL fwd_hi_untouched got %h exp %h", bus.rd_hi, hi_m); end
    @(posedge clk);
    model_edge(1'b0, 64'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    #1;
    wd = $urandom;
    set_idle();
    bus.wb_hi_we = 1'b1;
    bus.wb_wdata = wd;
    @(negedge clk);
    checks++; if (bus.rd_lo !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fwd_lo_next got %h exp deadbeef", bus.rd_lo); end
    checks++; if (bus.rd_hi !== exp_rd(hi_m, 1'b1, 1'b0, wd)) begin errors++; $display("FAIL fwd_hi_same got %h exp %h", bus.rd_hi, exp_rd(hi_m, 1'b1, 1'b0, wd)); end
    @(posedge clk);
    model_edge(1'b0, 64'h0, 1'b1, 1'b0, wd);
    #1;
    set_idle();
    @(negedge clk);
    checks++; if (bus.rd_hi !== wd) begin errors++; $display("FAIL fwd_hi_next got %h exp %h", bus.rd_hi, wd); end
    @(posedge clk); #1;
  endtask

  task automatic test_non_op;
    for (int i = 0; i < 8; i++) begin
      logic [4:0] c;
      logic v;
      c = 5'($urandom);
      v = 1'b1;
      if (c == MULT_CONTROL || c == MULTU_CONTROL || c == DIV_CONTROL || c == DIVU_CONTROL) v = 1'b0;
      bus.ex_valid   = v;
      bus.ex_control = c;
      @(negedge clk);
      checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL nonop_stall c=%h v=%b got %b exp 0", c, v, bus.stall); end
      checks++; if (bus.mdu_en !== 1'b0) begin errors++; $display("FAIL nonop_en c=%h v=%b got %b exp 0", c, v, bus.mdu_en); end
      checks++; if (bus.mdu_control !== 5'd0) begin errors++; $display("FAIL nonop_ctrl c=%h got %h exp 0", c, bus.mdu_control); end
      @(posedge clk); #1;
    end
    set_idle();
  endtask

  task automatic test_random_ops;
    for (int t = 0; t < 24; t++) begin
      logic [4:0] op;
      logic [31:0] a, b;
      logic [63:0] res;
      int n;
      case ($urandom_range(0, 3))
        0:       op = MULT_CONTROL;
        1:       op = MULTU_CONTROL;
        2:       op = DIV_CONTROL;
        default: op = DIVU_CONTROL;
      endcase
      a = $urandom;
      b = $urandom;
      if (b == 32'd0) b = 32'd1;
      if (op == DIV_CONTROL && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
      res = mdu_model(op, a, b);
      n = $urandom_range(0, 5);
      for (int k = 0; k <= n + 1; k++) begin
        logic rdy, hwe, lwe;
        logic [31:0] wd;
        rdy = (k == n + 1);
        hwe = ($urandom_range(0, 3) == 0);
        lwe = ($urandom_range(0, 3) == 0);
        wd  = $urandom;
        set_op(op, rdy, rdy ? res : {$urandom, $urandom});
        bus.flush    = 1'b0;
        bus.wb_hi_we = hwe;
        bus.wb_lo_we = lwe;
        bus.wb_wdata = wd;
        @(negedge clk);
        checks++; if (bus.stall !== (k <= n)) begin errors++; $display("FAIL rnd_stall t=%0d k=%0d got %b exp %b", t, k, bus.stall, k <= n); end
        checks++; if (bus.mdu_en !== 1'b1) begin errors++; $display("FAIL rnd_en t=%0d k=%0d got %b exp 1", t, k, bus.mdu_en); end
        checks++; if (bus.mdu_control !== op) begin errors++; $display("FAIL rnd_ctrl t=%0d k=%0d got %h exp %h", t, k, bus.mdu_control, op); end
        checks++; if (bus.rd_hi !== exp_rd(hi_m, hwe, rdy, wd)) begin errors++; $display("FAIL rnd_rd_hi t=%0d k=%0d got %h exp %h", t, k, bus.rd_hi, exp_rd(hi_m, hwe, rdy, wd)); end
        checks++; if (bus.rd_lo !== exp_rd(lo_m, lwe, rdy, wd)) begin errors++; $display("FAIL rnd_rd_lo t=%0d k=%0d got %h exp %h", t, k, bus.rd_lo, exp_rd(lo_m, lwe, rdy, wd)); end
        @(posedge clk);
        model_edge(rdy, res, hwe, lwe, wd);
        #1;
      end
      set_idle();
      @(negedge clk);
      checks++; if (bus.mdu_control !== 5'd0 || bus.mdu_en !== 1'b0) begin errors++; $display("FAIL rnd_done_drive t=%0d got ctrl %h en %b exp 0 0", t, bus.mdu_control, bus.mdu_en); end
      checks++; if ({bus.rd_hi, bus.rd_lo} !== {hi_m, lo_m}) begin errors++; $display("FAIL rnd_result t=%0d op=%h a=%h b=%h got %h exp %h", t, op, a, b, {bus.rd_hi, bus.rd_lo}, {hi_m, lo_m}); end
      checks++; if (bus.busy_cycles !== 6'(n)) begin errors++; $display("FAIL rnd_busy t=%0d got %0d exp %0d", t, bus.busy_cycles, n); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation;
    int n;
    n = 66;
    for (int k = 0; k <= n + 1; k++) begin
      set_op(MULTU_CONTROL, k == n + 1, (k == n + 1) ? 64'h5 : 64'h0);
      @(posedge clk);
      model_edge(k == n + 1, 64'h5, 1'b0, 1'b0, 32'h0);
      #1;
    end
    set_idle();
    @(negedge clk);
    checks++; if (bus.busy_cycles !== 6'd63) begin errors++; $display("FAIL sat_busy got %0d exp 63", bus.busy_cycles); end
    checks++; if (bus.rd_lo !== 32'h5) begin errors++; $display("FAIL sat_lo got %h exp 5", bus.rd_lo); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_busy;
    for (int k = 0; k < 3; k++) begin
      set_op(MULT_CONTROL, 1'b0, 64'h0);
      @(posedge clk); #1;
    end
    set_idle();
    rst = 1'b0;
    hi_m = '0;
    lo_m = '0;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall got %b exp 0", bus.stall); end
    checks++; if (bus.mdu_en !== 1'b0) begin errors++; $display("FAIL rstmid_en got %b exp 0", bus.mdu_en); end
    checks++; if (bus.mdu_control !== 5'd0) begin errors++; $display("FAIL rstmid_ctrl got %h exp 0", bus.mdu_control); end
    checks++; if (bus.busy_cycles !== 6'd0) begin errors++; $display("FAIL rstmid_busy got %0d exp 0", bus.busy_cycles); end
    checks++; if ({bus.rd_hi, bus.rd_lo} !== 64'h0) begin errors++; $display("FAIL rstmid_hilo got %h exp 0", {bus.rd_hi, bus.rd_lo}); end
    @(posedge clk); #1;
    rst = 1'b1;
    bus.mdu_ready  = 1'b1;
    bus.mdu_result = 64'hCAFE_F00D_1234_5678;
    @(negedge clk);
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rstmid_ready_stall got %b exp 0", bus.stall); end
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    checks++; if ({bus.rd_hi, bus.rd_lo} !== 64'h0) begin errors++; $display("FAIL rstmid_nocommit got %h exp 0", {bus.rd_hi, bus.rd_lo}); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_flush();
    test_mult();
    test_wb_collision();
    test_back_to_back();
    test_wb_fwd();
    test_non_op();
    test_random_ops();
    test_saturation();
    test_reset_mid_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
